// File: rtl/fetch_module.sv
// fetch_module: in-order instruction fetch feeding dispatch through a small
// fetch queue. One outstanding memory response at a time, data returns one
// cycle after its request. Optional feature macro: FETCH_PERF_CNT_EN adds
// saturating fetch and stall performance counters.
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif

module fetch_module #(
  parameter logic [`GPR_SIZE-1:0] RESET_PC = '0,
  parameter int                   FQ_DEPTH = 4
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_start,
  input  logic                 in_stall,
  input  logic                 in_redirect,
  input  logic [`GPR_SIZE-1:0] in_redirect_pc,
  output logic                 out_imem_req,
  output logic [`GPR_SIZE-1:0] out_imem_addr,
  input  logic [31:0]          in_imem_data,
  output logic [31:0]          out_insnbits,
  output logic [`GPR_SIZE-1:0] out_pc,
  output logic                 out_fetch_done,
  output logic                 out_halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          out_fetch_count,
  output logic [31:0]          out_stall_count
`endif
);

  localparam logic [31:0] HLT_WORD = 32'hD440_0000;
  localparam int          PTR_W    = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int          CNT_W    = $clog2(FQ_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [`GPR_SIZE-1:0]   fetch_pc;
  logic                   vld_p1;
  logic [`GPR_SIZE-1:0]   pc_p1;
  logic [31:0]            fq_insn [FQ_DEPTH];
  logic [`GPR_SIZE-1:0]   fq_pc   [FQ_DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W:0]         occupancy;
  logic                   req;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   not_empty;

  // Queue occupancy counts entries already stored plus the response in flight,
  // so a request is only issued when its response is guaranteed a slot.
  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(FQ_DEPTH));
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
  assign pop       = not_empty && !in_stall && !in_redirect;
  // Responses arriving outside RUN belong to requests issued after HLT.
  assign push      = vld_p1 && (state == S_RUN) && !in_redirect && (!full || pop);

  // FSM state register
  always_ff @(posedge in_clk) begin
    if (!in_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // FSM next state: redirect wins over every other transition
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_start) state_nxt = S_RUN;
      S_RUN:   if (push && (in_imem_data == HLT_WORD)) state_nxt = S_HALT;
      default: ;
    endcase
    if (in_redirect) state_nxt = S_RUN;
  end

  // FSM outputs: memory request and halted indication
  always_comb begin
    req           = 1'b0;
    out_imem_addr = '0;
    out_halted    = 1'b0;
    case (state)
      S_RUN: begin
        req = !in_redirect && (occupancy < (CNT_W+1)'(FQ_DEPTH));
        if (req) out_imem_addr = fetch_pc;
      end
      S_HALT:  out_halted = !not_empty;
      default: ;
    endcase
  end

  assign out_imem_req = req;

  // Fetch PC: advances by one word per issued request, wraps naturally
  always_ff @(posedge in_clk) begin
    if (!in_rst)          fetch_pc <= RESET_PC;
    else if (in_redirect) fetch_pc <= in_redirect_pc;
    else if (req)         fetch_pc <= fetch_pc + `GPR_SIZE'(4);
  end

  // ---- stage p1: response cycle, data arrives with the PC of its request ----
  // Track the single in-flight response and remember its request PC
  always_ff @(posedge in_clk) begin
    if (!in_rst) vld_p1 <= 1'b0;
    else         vld_p1 <= req;
    pc_p1 <= fetch_pc;
  end

  // ---- stage p2: queue write, head visible to dispatch ----
  // Queue storage: only written on push, contents qualified by count
  always_ff @(posedge in_clk) begin
    if (push) begin
      fq_insn[wr_ptr] <= in_imem_data;
      fq_pc[wr_ptr]   <= pc_p1;
    end
  end

  // Queue pointers and count; a redirect flushes the whole queue
  always_ff @(posedge in_clk) begin
    if (!in_rst || in_redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign out_fetch_done = not_empty;
  assign out_insnbits   = not_empty ? fq_insn[rd_ptr] : '0;
  assign out_pc         = not_empty ? fq_pc[rd_ptr]   : '0;

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Performance counters: consumed instructions and stalled head cycles
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      out_fetch_count <= '0;
      out_stall_count <= '0;
    end else begin
      if (pop)                  out_fetch_count <= sat_inc(out_fetch_count);
      if (not_empty && in_stall) out_stall_count <= sat_inc(out_stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_module.sv
// tb_fetch_module: self-checking bench for fetch_module. Directed scenarios
// plus a randomized stall/redirect run checked against a sequential-PC model.
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif

module tb_fetch_module;

  localparam logic [31:0] HLT = 32'hD440_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start, stall, redirect;
  logic [`GPR_SIZE-1:0] redirect_pc;
  logic                 imem_req;
  logic [`GPR_SIZE-1:0] imem_addr;
  logic [31:0]          imem_data;
  logic [31:0]          insn;
  logic [`GPR_SIZE-1:0] pc;
  logic                 done, halted;

  logic                 rst2, start2, stall2, redirect2;
  logic [`GPR_SIZE-1:0] redirect_pc2;
  logic                 imem_req2;
  logic [`GPR_SIZE-1:0] imem_addr2;
  logic [31:0]          imem_data2;
  logic [31:0]          insn2;
  logic [`GPR_SIZE-1:0] pc2;
  logic                 done2, halted2;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt, scnt, fcnt2, scnt2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [logic [`GPR_SIZE-1:0]];
  logic [31:0] salt;
  bit          hlt_en;

  fetch_module #(.RESET_PC('0), .FQ_DEPTH(4)) u_dut (
    .in_clk(clk), .in_rst(rst), .in_start(start), .in_stall(stall),
    .in_redirect(redirect), .in_redirect_pc(redirect_pc),
    .out_imem_req(imem_req), .out_imem_addr(imem_addr), .in_imem_data(imem_data),
    .out_insnbits(insn), .out_pc(pc), .out_fetch_done(done), .out_halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .out_fetch_count(fcnt), .out_stall_count(scnt)
`endif
  );

  fetch_module #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .FQ_DEPTH(4)) u_dut2 (
    .in_clk(clk), .in_rst(rst2), .in_start(start2), .in_stall(stall2),
    .in_redirect(redirect2), .in_redirect_pc(redirect_pc2),
    .out_imem_req(imem_req2), .out_imem_addr(imem_addr2), .in_imem_data(imem_data2),
    .out_insnbits(insn2), .out_pc(pc2), .out_fetch_done(done2), .out_halted(halted2)
`ifdef FETCH_PERF_CNT_EN
    , .out_fetch_count(fcnt2), .out_stall_count(scnt2)
`endif
  );

  // Memory contents: explicit entries first, else a hash of the address
  function automatic logic [31:0] word(input logic [`GPR_SIZE-1:0] a);
    logic [31:0] h;
    if (mem.exists(a)) return mem[a];
    h = (a[31:0] * 32'h9E37_79B1) ^ salt;
    if (hlt_en && h[31:28] == 4'h0) return HLT;
    return {4'h1, h[27:0]};
  endfunction

  // Instruction memory: data valid exactly one cycle after each request
  always @(posedge clk) begin
    imem_data  <= imem_req  ? word(imem_addr)  : (32'h2000_0000 | ($urandom() & 32'h0FFF_FFFF));
    imem_data2 <= imem_req2 ? word(imem_addr2) : 32'h2BAD_0000;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    n_checks++; if (imem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_checks++; if (insn !== 32'h0) begin n_fail++; $display("FAIL reset_insn: got %h want 0", insn); end
    n_checks++; if (pc !== '0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b want 0", halted); end
    bad = 0;
    repeat (4) begin
      tick();
      if (imem_req !== 1'b0 || done !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL reset_idle_hold: %0d active cycles, want 0", bad); end
  endtask

  task automatic test_basic();
    do_reset();
    mem.delete();
    mem[0] = 32'h913F_FC21;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req: got %0b want 1", imem_req); end
    n_checks++; if (imem_addr !== '0) begin n_fail++; $display("FAIL basic_addr: got %h want 0", imem_addr); end
    tick(); tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %0b want 1", done); end
    n_checks++; if (insn !== 32'h913F_FC21) begin n_fail++; $display("FAIL basic_insn: got %h want 913ffc21", insn); end
    n_checks++; if (pc !== '0) begin n_fail++; $display("FAIL basic_pc: got %h want 0", pc); end
  endtask

  task automatic test_stall();
    logic [`GPR_SIZE-1:0] want;
    do_reset();
    mem.delete();
    stall = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_full_req: got %0b want 0", imem_req); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_full_done: got %0b want 1", done); end
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      want = `GPR_SIZE'(4 * i);
      n_checks++;
      if (done !== 1'b1 || pc !== want || insn !== word(want)) begin
        n_fail++;
        $display("FAIL stall_release[%0d]: got done=%0b pc=%h insn=%h want done=1 pc=%h insn=%h",
                 i, done, pc, insn, want, word(want));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    bit got;
    do_reset();
    mem.delete();
    stall = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_checks++; if (done !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_pre: got done=%0b req=%0b want 1/0", done, imem_req); end
    redirect = 1'b1; redirect_pc = `GPR_SIZE'(64'h100); stall = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_no_req: got %0b want 0", imem_req); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got done=%0b want 0", done); end
    redirect = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== `GPR_SIZE'(64'h100)) begin n_fail++; $display("FAIL redir_req: got req=%0b addr=%h want 1/100", imem_req, imem_addr); end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (done === 1'b1) got = 1'b1;
      else tick();
    end
    n_checks++;
    if (!got || pc !== `GPR_SIZE'(64'h100) || insn !== word(`GPR_SIZE'(64'h100))) begin
      n_fail++;
      $display("FAIL redir_deliver: got seen=%0b pc=%h insn=%h want pc=100 insn=%h", got, pc, insn, word(`GPR_SIZE'(64'h100)));
    end
  endtask

  task automatic test_halt();
    int c8, late;
    logic [`GPR_SIZE-1:0] got[$];
    logic [31:0] insn8;
    do_reset();
    mem.delete();
    mem[8] = HLT;
    start = 1'b1;
    tick();
    start = 1'b0;
    c8 = -1; late = 0; insn8 = '0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (imem_req === 1'b1) begin
        if (imem_addr === `GPR_SIZE'(8)) c8 = cyc;
        else if (c8 >= 0 && cyc > c8 + 1) late++;
      end
      if (done === 1'b1) begin
        got.push_back(pc);
        if (pc === `GPR_SIZE'(8)) insn8 = insn;
      end
      tick();
    end
    n_checks++;
    if (got.size() != 3) begin n_fail++; $display("FAIL halt_count: got %0d deliveries want 3", got.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got[i] !== `GPR_SIZE'(4 * i)) begin n_fail++; $display("FAIL halt_pc[%0d]: got %h want %h", i, got[i], 4 * i); end
      end
    end
    n_checks++; if (insn8 !== HLT) begin n_fail++; $display("FAIL halt_insn: got %h want d4400000", insn8); end
    n_checks++; if (c8 < 0 || late != 0) begin n_fail++; $display("FAIL halt_no_req: got hlt_req_cycle=%0d late_reqs=%0d want >=0/0", c8, late); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted: got %0b want 1", halted); end
  endtask

  task automatic test_reset_midrun();
    int bad;
    do_reset();
    mem.delete();
    stall = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got done=%0b want 1", done); end
    rst = 1'b0;
    tick();
    rst = 1'b1; stall = 1'b0;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== '0 || insn !== 32'h0 || pc !== '0 || done !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got req=%0b addr=%h insn=%h pc=%h done=%0b halted=%0b want all 0",
               imem_req, imem_addr, insn, pc, done, halted);
    end
    bad = 0;
    repeat (5) begin
      tick();
      if (imem_req !== 1'b0 || done !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midrst_idle: %0d active cycles, want 0", bad); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== '0) begin n_fail++; $display("FAIL midrst_restart: got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_random();
    logic [`GPR_SIZE-1:0] exp_pc;
    bit halted_exp;
    int deliveries;
    do_reset();
    mem.delete();
    hlt_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_pc = '0; halted_exp = 1'b0; deliveries = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      stall    = ($urandom_range(99) < 30);
      redirect = halted_exp ? ($urandom_range(3) == 0) : ($urandom_range(99) < 3);
      if (redirect) begin
        redirect_pc = {$urandom(), $urandom()};
        redirect_pc[1:0] = 2'b00;
      end
      #1;
      if (halted_exp) begin
        n_checks++;
        if (halted !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL rand_halted[%0d]: got halted=%0b done=%0b want 1/0", cyc, halted, done); end
      end
      if (done === 1'b1 && !stall && !redirect) begin
        n_checks++;
        if (pc !== exp_pc || insn !== word(exp_pc)) begin
          n_fail++;
          $display("FAIL rand_deliver[%0d]: got pc=%h insn=%h want pc=%h insn=%h", cyc, pc, insn, exp_pc, word(exp_pc));
        end
        deliveries++;
        if (word(exp_pc) == HLT) halted_exp = 1'b1;
        exp_pc = exp_pc + `GPR_SIZE'(4);
      end
      if (redirect) begin
        exp_pc = redirect_pc;
        halted_exp = 1'b0;
      end
      tick();
    end
    redirect = 1'b0; stall = 1'b0; hlt_en = 1'b0;
    n_checks++; if (deliveries < 100) begin n_fail++; $display("FAIL rand_progress: got %0d deliveries want >=100", deliveries); end
  endtask

  task automatic test_reset_pc();
    logic [`GPR_SIZE-1:0] got[$];
    logic [31:0] gins[$];
    mem.delete();
    rst2 = 1'b0; start2 = 1'b0;
    tick(); tick();
    rst2 = 1'b1;
    n_checks++; if (imem_req2 !== 1'b0 || done2 !== 1'b0) begin n_fail++; $display("FAIL rpc_reset: got req=%0b done=%0b want 0/0", imem_req2, done2); end
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n_checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== `GPR_SIZE'(64'hFFFF_FFFF_FFFF_FFFC)) begin n_fail++; $display("FAIL rpc_req: got req=%0b addr=%h want 1/fffffffffffffffc", imem_req2, imem_addr2); end
    for (int i = 0; i < 20; i++) begin
      if (done2 === 1'b1 && got.size() < 2) begin
        got.push_back(pc2);
        gins.push_back(insn2);
      end
      tick();
    end
    n_checks++;
    if (got.size() != 2) begin n_fail++; $display("FAIL rpc_count: got %0d deliveries want 2", got.size()); end
    else begin
      n_checks++;
      if (got[0] !== `GPR_SIZE'(64'hFFFF_FFFF_FFFF_FFFC) || gins[0] !== word(`GPR_SIZE'(64'hFFFF_FFFF_FFFF_FFFC))) begin
        n_fail++; $display("FAIL rpc_first: got pc=%h insn=%h want fffffffffffffffc", got[0], gins[0]);
      end
      n_checks++;
      if (got[1] !== '0 || gins[1] !== word('0)) begin
        n_fail++; $display("FAIL rpc_wrap: got pc=%h insn=%h want pc=0 insn=%h", got[1], gins[1], word('0));
      end
    end
  endtask

  initial begin
    salt = $urandom();
    hlt_en = 1'b0;
    rst2 = 1'b0; start2 = 1'b0; stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_halt();
    test_reset_midrun();
    test_random();
    test_reset_pc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_module.md
FETCH_MODULE -- requirements
Module: fetch_module

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, giving the first fetch address after in_start.
REQ-002 The block SHALL have parameter FQ_DEPTH, default 4, giving the fetch queue entry count (power of two, 2..16).
REQ-003 The block SHALL have port in_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port in_rst, input, 1, a synchronous, active-low reset.
REQ-005 The block SHALL have port in_start, input, 1, which starts fetching from IDLE.
REQ-006 The block SHALL have port in_stall, input, 1, asserted by dispatch when it cannot accept an instruction.
REQ-007 The block SHALL have port in_redirect, input, 1, a misprediction flush request from the ROB.
REQ-008 The block SHALL have port in_redirect_pc, input, `GPR_SIZE, the new fetch address on redirect.
REQ-009 The block SHALL have port out_imem_req, output, 1, the instruction-memory read strobe.
REQ-010 The block SHALL have port out_imem_addr, output, `GPR_SIZE, the read address, valid when out_imem_req is high.
REQ-011 The block SHALL have port in_imem_data, input, 32, the read data, valid exactly one cycle after its request.
REQ-012 The block SHALL have port out_insnbits, output, 32, the instruction word at the queue head (0 when empty).
REQ-013 The block SHALL have port out_pc, output, `GPR_SIZE, the PC at the queue head (0 when empty).
REQ-014 The block SHALL have port out_fetch_done, output, 1, high when the queue is non-empty.
REQ-015 The block SHALL have port out_halted, output, 1, high in HALT with an empty queue.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and HALT: IDLE->RUN on in_start; RUN->HALT when an HLT word (32'hD440_0000) is written to the queue; any state->RUN on in_redirect.
REQ-017 In RUN, out_imem_req SHALL be high, with out_imem_addr=fetch_pc, iff (queue count + in-flight responses) < FQ_DEPTH and in_redirect is low.
REQ-018 Each issued request SHALL advance fetch_pc by 4 next cycle, wrapping modulo 2^`GPR_SIZE.
REQ-019 A response SHALL be written into the queue with its request PC on the edge ending the response cycle, unless it is discarded.
REQ-020 A queue entry SHALL be consumed on an edge where out_fetch_done=1 and in_stall=0; head outputs SHALL be combinational from the queue.
REQ-021 A simultaneous push and pop SHALL keep the count unchanged, including when full; the queue SHALL never overflow or underflow.
REQ-022 When in_redirect=1, the block SHALL empty the queue, discard any response due next cycle, set fetch_pc=in_redirect_pc, and issue no request that cycle; redirect overrides push, pop and in_start.
REQ-023 Responses for requests issued after the HLT request SHALL be discarded; HLT itself SHALL be delivered to dispatch.
REQ-024 Minimum latency from request to out_fetch_done SHALL be 2 cycles (request cycle t, data t+1, visible t+2).
REQ-025 In IDLE and HALT, out_imem_req SHALL be 0.

Reset
REQ-026 On an edge with in_rst=0, the block SHALL enter IDLE, set fetch_pc=RESET_PC, empty the queue and clear in-flight tracking, overriding all other inputs.
REQ-027 After reset, out_imem_req, out_imem_addr, out_insnbits, out_pc, out_fetch_done and out_halted SHALL all be 0.

Configuration
REQ-028 With FETCH_PERF_CNT_EN defined, the block SHALL add 32-bit outputs out_fetch_count (increments per consumed instruction) and out_stall_count (increments per cycle with out_fetch_done=1 and in_stall=1); both SHALL be reset to 0 and saturate at all-ones.
REQ-029 Without FETCH_PERF_CNT_EN, neither port nor its counter SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL check: reset, then in_start at cycle 0 with mem[0]=32'h913F_FC21 -> out_imem_req=1, addr 0 at cycle 1; out_fetch_done=1, insnbits 32'h913F_FC21, pc 0 at cycle 3.
REQ-031 The bench SHALL check: in_stall held high 10 cycles after start -> queue holds pcs 0,4,8,12, out_imem_req=0; on release, the pcs are delivered one per cycle in order.
REQ-032 The bench SHALL check: in_redirect with in_redirect_pc=64'h100 while the queue holds 3 entries and 1 is in flight -> out_fetch_done=0 next cycle, and the next delivered pc=64'h100.
REQ-033 The bench SHALL check: HLT at address 8 -> pcs 0,4,8 are delivered, no request follows HLT's response, and out_halted=1 after pc 8 is consumed.
REQ-034 The bench SHALL check: in_rst=0 mid-run with a full queue -> all outputs are 0 next cycle and the block stays IDLE until in_start.
REQ-035 The bench SHALL check: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> delivered pcs FFFF_FFFF_FFFF_FFFC, then 0.
